// File: rtl/fetch_pc_unit_pkg.sv
// rtl/fetch_pc_unit_pkg.sv - shared defaults and next-PC select encoding for the fetch unit
package fetch_pc_unit_pkg;

    localparam int          DATA_WIDTH_DEF    = 32;
    localparam logic [31:0] RESET_ADDRESS_DEF = 32'h0000_0000;
    // sll $0,$0,0
    localparam logic [31:0] NOP_DEF           = 32'h0000_0000;

    typedef enum logic [1:0] {
        SEL_SEQ    = 2'd0,
        SEL_BRANCH = 2'd1,
        SEL_JUMP   = 2'd2,
        SEL_JR     = 2'd3
    } next_pc_sel_e;

endpackage

// File: rtl/fetch_pc_unit_next_pc_select.sv
// rtl/fetch_pc_unit_next_pc_select.sv - next-PC priority mux and redirect target arithmetic
module fetch_pc_unit_next_pc_select
    import fetch_pc_unit_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic [DATA_WIDTH-1:0] i_pc,
    input  logic [DATA_WIDTH-1:0] i_if_id_pcplus4,
    input  logic                  i_if_id_valid,
    input  logic                  i_stall,
    input  logic                  i_branch_taken,
    input  logic [15:0]           i_branch_offset,
    input  logic                  i_jump,
    input  logic [25:0]           i_jump_field,
    input  logic                  i_jump_register,
    input  logic [DATA_WIDTH-1:0] i_register_target,
    output logic [DATA_WIDTH-1:0] o_pc_plus4,
    output logic [DATA_WIDTH-1:0] o_next_pc,
    output next_pc_sel_e          o_sel,
    output logic                  o_misaligned
);

    logic [DATA_WIDTH-1:0] w_branch_target;
    logic [DATA_WIDTH-1:0] w_jump_target;
    logic [DATA_WIDTH-1:0] w_jr_target;

    // Targets are relative to the instruction sitting in ID, not the fetch PC
    always_comb begin
        o_pc_plus4      = i_pc + DATA_WIDTH'(4);
        w_branch_target = i_if_id_pcplus4
                        + {{(DATA_WIDTH-18){i_branch_offset[15]}}, i_branch_offset, 2'b00};
        w_jump_target   = {i_if_id_pcplus4[DATA_WIDTH-1:28], i_jump_field, 2'b00};
        // A misaligned JR target is forced onto a word boundary; the error is flagged separately
        w_jr_target     = {i_register_target[DATA_WIDTH-1:2], 2'b00};
    end

    // Redirects only count when ID holds a real instruction and fetch is not stalled
    always_comb begin
        o_sel = SEL_SEQ;
        if (!i_stall && i_if_id_valid) begin
            if (i_jump_register)     o_sel = SEL_JR;
            else if (i_jump)         o_sel = SEL_JUMP;
            else if (i_branch_taken) o_sel = SEL_BRANCH;
        end
    end

    // Final mux: stall holds the PC, otherwise follow the selected source
    always_comb begin
        o_next_pc    = o_pc_plus4;
        o_misaligned = (o_sel == SEL_JR) && (i_register_target[1:0] != 2'b00);
        if (i_stall) begin
            o_next_pc = i_pc;
        end else begin
            case (o_sel)
                SEL_JR:     o_next_pc = w_jr_target;
                SEL_JUMP:   o_next_pc = w_jump_target;
                SEL_BRANCH: o_next_pc = w_branch_target;
                default:    o_next_pc = o_pc_plus4;
            endcase
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - PC register, next-PC selection and IF/ID pipeline register
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter int                    DATA_WIDTH      = DATA_WIDTH_DEF,
    parameter logic [DATA_WIDTH-1:0] RESET_ADDRESS   = DATA_WIDTH'(RESET_ADDRESS_DEF),
    parameter logic [DATA_WIDTH-1:0] NOP_INSTRUCTION = DATA_WIDTH'(NOP_DEF)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Stall,
    input  logic                  Flush,
    input  logic                  BranchTaken,
    input  logic [15:0]           BranchOffset,
    input  logic                  Jump,
    input  logic [25:0]           JumpField,
    input  logic                  JumpRegister,
    input  logic [DATA_WIDTH-1:0] RegisterTarget,
    input  logic [DATA_WIDTH-1:0] Instruction,
    output logic [DATA_WIDTH-1:0] PC,
    output logic [DATA_WIDTH-1:0] IF_ID_Instruction,
    output logic [DATA_WIDTH-1:0] IF_ID_PCPlus4,
    output logic                  IF_ID_Valid,
    output logic                  AddressError
);

    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_if_id_instr;
    logic [DATA_WIDTH-1:0] r_if_id_pcplus4;
    logic                  r_if_id_valid;
    logic                  r_address_error;

    logic [DATA_WIDTH-1:0] w_pc_plus4;
    logic [DATA_WIDTH-1:0] w_next_pc;
    next_pc_sel_e          w_sel;
    logic                  w_misaligned;
    logic                  w_redirect;

    fetch_pc_unit_next_pc_select #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_next_pc_select (
        .i_pc              (r_pc),
        .i_if_id_pcplus4   (r_if_id_pcplus4),
        .i_if_id_valid     (r_if_id_valid),
        .i_stall           (Stall),
        .i_branch_taken    (BranchTaken),
        .i_branch_offset   (BranchOffset),
        .i_jump            (Jump),
        .i_jump_field      (JumpField),
        .i_jump_register   (JumpRegister),
        .i_register_target (RegisterTarget),
        .o_pc_plus4        (w_pc_plus4),
        .o_next_pc         (w_next_pc),
        .o_sel             (w_sel),
        .o_misaligned      (w_misaligned)
    );

    assign w_redirect = (w_sel != SEL_SEQ);

    // Program counter; stall hold is already folded into w_next_pc
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_pc <= RESET_ADDRESS;
        else        r_pc <= w_next_pc;
    end

    // IF/ID slot: hold on stall, squash on flush or taken redirect, else capture fetch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_if_id_instr   <= NOP_INSTRUCTION;
            r_if_id_pcplus4 <= '0;
            r_if_id_valid   <= 1'b0;
        end else if (!Stall) begin
            r_if_id_pcplus4 <= w_pc_plus4;
            if (Flush || w_redirect) begin
                r_if_id_instr <= NOP_INSTRUCTION;
                r_if_id_valid <= 1'b0;
            end else begin
                r_if_id_instr <= Instruction;
                r_if_id_valid <= 1'b1;
            end
        end
    end

    // Sticky flag for a misaligned JR target; only reset clears it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)            r_address_error <= 1'b0;
        else if (w_misaligned) r_address_error <= 1'b1;
    end

    assign PC                = r_pc;
    assign IF_ID_Instruction = r_if_id_instr;
    assign IF_ID_PCPlus4     = r_if_id_pcplus4;
    assign IF_ID_Valid       = r_if_id_valid;
    assign AddressError      = r_address_error;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - directed self-checking bench for fetch_pc_unit
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        Stall = 1'b0;
    logic        Flush = 1'b0;
    logic        BranchTaken = 1'b0;
    logic [15:0] BranchOffset = 16'h0;
    logic        Jump = 1'b0;
    logic [25:0] JumpField = 26'h0;
    logic        JumpRegister = 1'b0;
    logic [31:0] RegisterTarget = 32'h0;
    logic [31:0] Instruction;
    logic [31:0] PC;
    logic [31:0] IF_ID_Instruction;
    logic [31:0] IF_ID_PCPlus4;
    logic        IF_ID_Valid;
    logic        AddressError;

    int total = 0;
    int bad   = 0;

    // rom[n] = 0xAB000000 | n, word address n = PC >> 2
    assign Instruction = 32'hAB00_0000 | (PC >> 2);

    always #5 clk = ~clk;

    fetch_pc_unit dut (
        .clk               (clk),
        .reset             (reset),
        .Stall             (Stall),
        .Flush             (Flush),
        .BranchTaken       (BranchTaken),
        .BranchOffset      (BranchOffset),
        .Jump              (Jump),
        .JumpField         (JumpField),
        .JumpRegister      (JumpRegister),
        .RegisterTarget    (RegisterTarget),
        .Instruction       (Instruction),
        .PC                (PC),
        .IF_ID_Instruction (IF_ID_Instruction),
        .IF_ID_PCPlus4     (IF_ID_PCPlus4),
        .IF_ID_Valid       (IF_ID_Valid),
        .AddressError      (AddressError)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compares all five outputs against one expected vector
    task automatic expect_state(input string name, input logic [31:0] pc, input logic [31:0] ins,
                                input logic [31:0] p4, input logic v, input logic ae);
        total++;
        if (PC !== pc || IF_ID_Instruction !== ins || IF_ID_PCPlus4 !== p4 ||
            IF_ID_Valid !== v || AddressError !== ae) begin
            bad++;
            $display("FAIL %s got pc=%h ins=%h p4=%h v=%b ae=%b exp pc=%h ins=%h p4=%h v=%b ae=%b",
                     name, PC, IF_ID_Instruction, IF_ID_PCPlus4, IF_ID_Valid, AddressError,
                     pc, ins, p4, v, ae);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        expect_state("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        reset = 1'b1;
    endtask

    task automatic test_sequential();
        for (int k = 1; k <= 4; k++) begin
            step();
            expect_state("seq", 32'(4*k), 32'hAB00_0000 | 32'(k-1), 32'(4*k), 1'b1, 1'b0);
        end
    endtask

    task automatic test_branch();
        BranchTaken = 1'b1; BranchOffset = 16'hFFFE;
        step();
        expect_state("branch_redirect", 32'h8, 32'h0, 32'h14, 1'b0, 1'b0);
        BranchTaken = 1'b0;
        step();
        expect_state("branch_target", 32'hC, 32'hAB00_0002, 32'hC, 1'b1, 1'b0);
    endtask

    task automatic test_priority();
        Jump = 1'b1; JumpField = 26'h000_0040; JumpRegister = 1'b1; RegisterTarget = 32'h20;
        step();
        expect_state("prio_jr", 32'h20, 32'h0, 32'h10, 1'b0, 1'b0);
        Jump = 1'b0; JumpRegister = 1'b0;
        step();
        expect_state("prio_after", 32'h24, 32'hAB00_0008, 32'h24, 1'b1, 1'b0);
    endtask

    task automatic test_jump();
        Jump = 1'b1; JumpField = 26'h000_0040;
        step();
        expect_state("jump_redirect", 32'h100, 32'h0, 32'h28, 1'b0, 1'b0);
        Jump = 1'b0;
        step();
        expect_state("jump_target", 32'h104, 32'hAB00_0040, 32'h104, 1'b1, 1'b0);
    endtask

    task automatic test_stall();
        BranchTaken = 1'b1; BranchOffset = 16'h0004; Stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            expect_state("stall_hold", 32'h104, 32'hAB00_0040, 32'h104, 1'b1, 1'b0);
        end
        Stall = 1'b0;
        step();
        expect_state("stall_release", 32'h114, 32'h0, 32'h108, 1'b0, 1'b0);
        BranchTaken = 1'b0;
        step();
        expect_state("stall_target", 32'h118, 32'hAB00_0045, 32'h118, 1'b1, 1'b0);
    endtask

    task automatic test_misaligned();
        JumpRegister = 1'b1; RegisterTarget = 32'h23;
        step();
        expect_state("misalign_jr", 32'h20, 32'h0, 32'h11C, 1'b0, 1'b1);
        JumpRegister = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            expect_state("misalign_sticky", 32'(32'h20 + 4*k), 32'hAB00_0000 | 32'(7+k),
                         32'(32'h20 + 4*k), 1'b1, 1'b1);
        end
    endtask

    task automatic test_wrap();
        JumpRegister = 1'b1; RegisterTarget = 32'hFFFF_FFFC;
        step();
        expect_state("wrap_jr", 32'hFFFF_FFFC, 32'h0, 32'h4C, 1'b0, 1'b1);
        JumpRegister = 1'b0;
        step();
        expect_state("wrap_seq", 32'h0, 32'hBFFF_FFFF, 32'h0, 1'b1, 1'b1);
    endtask

    task automatic test_flush();
        Flush = 1'b1;
        step();
        expect_state("flush", 32'h4, 32'h0, 32'h4, 1'b0, 1'b1);
        Flush = 1'b0;
        step();
        expect_state("flush_after", 32'h8, 32'hAB00_0001, 32'h8, 1'b1, 1'b1);
        Stall = 1'b1; Flush = 1'b1;
        step();
        expect_state("stall_beats_flush", 32'h8, 32'hAB00_0001, 32'h8, 1'b1, 1'b1);
        Stall = 1'b0;
        step();
        expect_state("flush_after_stall", 32'hC, 32'h0, 32'hC, 1'b0, 1'b1);
        Flush = 1'b0; BranchTaken = 1'b1; BranchOffset = 16'hFFFE;
        step();
        expect_state("redirect_ignored_invalid", 32'h10, 32'hAB00_0003, 32'h10, 1'b1, 1'b1);
        BranchTaken = 1'b0;
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        expect_state("async_reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        step();
        expect_state("reset_release", 32'h4, 32'hAB00_0000, 32'h4, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_priority();
        test_jump();
        test_stall();
        test_misaligned();
        test_wrap();
        test_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
